dp_header_inserter: RTL and testbench

DP_HEADER_INSERTER -- requirements
Module: dp_header_inserter

---
 rtl/dp_pkg.sv | 14 +
 rtl/dp_hdr_beat_mux.sv | 16 +
 rtl/dp_header_inserter.sv | 114 +++++++++++
 tb/tb_dp_header_inserter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// dp_pkg: state encodings shared by the data-path header insert and drop/parse orchestrators.
package dp_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE         = 2'd0,
        SEND_HEADER  = 2'd1,
        SEND_PAYLOAD = 2'd2
    } ins_state_t;
    typedef enum logic [STATE_W-1:0] {
        DROP_IDLE    = 2'd0,
        DROP_HEADER  = 2'd1,
        DROP_PAYLOAD = 2'd2
    } drop_state_t;
endpackage

// File: rtl/dp_hdr_beat_mux.sv
// dp_hdr_beat_mux: picks header beat idx out of the latched multi-beat header word.
module dp_hdr_beat_mux #(
    parameter int DATA_WIDTH    = 64,
    parameter int HDR_BEATS     = 2,
    parameter int COUNTER_WIDTH = 2
) (
    input  logic [HDR_BEATS*DATA_WIDTH-1:0] hdr_data,
    input  logic [COUNTER_WIDTH-1:0]        idx,
    output logic [DATA_WIDTH-1:0]           beat
);
    always_comb begin
        beat = '0;
        for (int i = 0; i < HDR_BEATS; i++)
            if (idx == COUNTER_WIDTH'(i)) beat = hdr_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
endmodule

// File: rtl/dp_header_inserter.sv
// dp_header_inserter: prepends a latched HDR_BEATS-beat header to each AXI-Stream packet,
// then passes the payload through with no added latency.
module dp_header_inserter
    import dp_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int HDR_BEATS     = 2,
    parameter int COUNTER_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [HDR_BEATS*DATA_WIDTH-1:0] s_hdr_data,
    input  logic                            s_hdr_no_payload,
    input  logic                            s_hdr_valid,
    output logic                            s_hdr_ready,
    input  logic [DATA_WIDTH-1:0]           s_axis_dp_top_tdata,
    input  logic [KEEP_WIDTH-1:0]           s_axis_dp_top_tkeep,
    input  logic                            s_axis_dp_top_tvalid,
    input  logic                            s_axis_dp_top_tlast,
    output logic                            s_axis_dp_top_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_dp_top_tdata,
    output logic [KEEP_WIDTH-1:0]           m_axis_dp_top_tkeep,
    output logic                            m_axis_dp_top_tvalid,
    output logic                            m_axis_dp_top_tlast,
    input  logic                            m_axis_dp_top_tready,
    output logic [STATE_W-1:0]              out_state,
    output logic [COUNTER_WIDTH-1:0]        out_count,
    output logic [15:0]                     out_pkt_count
);
    localparam logic [COUNTER_WIDTH-1:0] LAST_BEAT = COUNTER_WIDTH'(HDR_BEATS - 1);

    ins_state_t                      state_q, state_d;
    logic [COUNTER_WIDTH-1:0]        count_q, count_d;
    logic [HDR_BEATS*DATA_WIDTH-1:0] hdr_q, hdr_d;
    logic                            no_payload_q, no_payload_d;
    logic [15:0]                     pkt_count_q, pkt_count_d;
    logic [DATA_WIDTH-1:0]           hdr_beat;

    dp_hdr_beat_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .HDR_BEATS(HDR_BEATS),
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_beat_mux (
        .hdr_data(hdr_q),
        .idx(count_q),
        .beat(hdr_beat)
    );

    always_comb begin
        state_d              = state_q;
        count_d              = count_q;
        hdr_d                = hdr_q;
        no_payload_d         = no_payload_q;
        s_hdr_ready          = 1'b0;
        s_axis_dp_top_tready = 1'b0;
        m_axis_dp_top_tvalid = 1'b0;
        m_axis_dp_top_tdata  = '0;
        m_axis_dp_top_tkeep  = '0;
        m_axis_dp_top_tlast  = 1'b0;
        case (state_q)
            IDLE: begin
                // Reset already pins state to IDLE, so only the header ready needs explicit gating.
                s_hdr_ready = !rst;
                if (s_hdr_valid && !rst) begin
                    hdr_d        = s_hdr_data;
                    no_payload_d = s_hdr_no_payload;
                    count_d      = '0;
                    state_d      = SEND_HEADER;
                end
            end
            SEND_HEADER: begin
                m_axis_dp_top_tvalid = 1'b1;
                m_axis_dp_top_tdata  = hdr_beat;
                m_axis_dp_top_tkeep  = '1;
                m_axis_dp_top_tlast  = (count_q == LAST_BEAT) && no_payload_q;
                if (m_axis_dp_top_tready) begin
                    if (count_q != LAST_BEAT) count_d = count_q + 1'b1;
                    else state_d = no_payload_q ? IDLE : SEND_PAYLOAD;
                end
            end
            SEND_PAYLOAD: begin
                m_axis_dp_top_tvalid = s_axis_dp_top_tvalid;
                m_axis_dp_top_tdata  = s_axis_dp_top_tdata;
                m_axis_dp_top_tkeep  = s_axis_dp_top_tkeep;
                m_axis_dp_top_tlast  = s_axis_dp_top_tlast;
                s_axis_dp_top_tready = m_axis_dp_top_tready;
                if (s_axis_dp_top_tvalid && m_axis_dp_top_tready && s_axis_dp_top_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        pkt_count_d = pkt_count_q + 16'(m_axis_dp_top_tvalid && m_axis_dp_top_tready && m_axis_dp_top_tlast);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            hdr_q        <= '0;
            no_payload_q <= 1'b0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            hdr_q        <= hdr_d;
            no_payload_q <= no_payload_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign out_state     = state_q;
    assign out_count     = count_q;
    assign out_pkt_count = pkt_count_q;
endmodule

// File: tb/tb_dp_header_inserter.sv
// tb_dp_header_inserter: randomized packets against a queue-based model of the expected output stream.
module tb_dp_header_inserter;
    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        first;
    } beat_t;
    typedef struct packed {
        logic [127:0] d;
        logic         np;
    } hdr_t;

    logic         clk = 0;
    logic         rst = 1;
    logic [127:0] s_hdr_data = '0;
    logic         s_hdr_np = 0, s_hdr_valid = 0, s_hdr_ready;
    logic [63:0]  s_tdata = '0, m_tdata;
    logic [7:0]   s_tkeep = '0, m_tkeep;
    logic         s_tvalid = 0, s_tlast = 0, s_tready;
    logic         m_tvalid, m_tlast, m_tready = 0;
    logic [1:0]   out_state, out_count;
    logic [15:0]  out_pkt_count;

    int        total = 0, bad = 0, cyc = 0, tr_mode = 0;
    logic [15:0] exp_pkts = 0;
    beat_t     exp_q[$], pq[$];
    hdr_t      hq[$];
    int        hs_q[$];

    dp_header_inserter #(
        .DATA_WIDTH(64), .KEEP_WIDTH(8), .HDR_BEATS(2), .COUNTER_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .s_hdr_data(s_hdr_data), .s_hdr_no_payload(s_hdr_np),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
        .s_axis_dp_top_tdata(s_tdata), .s_axis_dp_top_tkeep(s_tkeep),
        .s_axis_dp_top_tvalid(s_tvalid), .s_axis_dp_top_tlast(s_tlast),
        .s_axis_dp_top_tready(s_tready),
        .m_axis_dp_top_tdata(m_tdata), .m_axis_dp_top_tkeep(m_tkeep),
        .m_axis_dp_top_tvalid(m_tvalid), .m_axis_dp_top_tlast(m_tlast),
        .m_axis_dp_top_tready(m_tready),
        .out_state(out_state), .out_count(out_count), .out_pkt_count(out_pkt_count)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected output: header beats (beat 0 first), then payload beats unchanged.
    task automatic add_pkt(input logic [127:0] h, input bit np, input int len, input logic [63:0] base, input bit rnd);
        beat_t b;
        hq.push_back('{h, np});
        for (int j = 0; j < 2; j++) exp_q.push_back('{h[j*64 +: 64], 8'hFF, np && j == 1, j == 0});
        for (int k = 0; k < (np ? 0 : len); k++) begin
            b.d = rnd ? {$urandom, $urandom} : base + 64'(k);
            b.k = rnd ? 8'($urandom) : 8'hFF;
            b.l = (k == len - 1);
            b.first = 0;
            pq.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_acc(input bit hdr, output bit ok);
        int n;
        n = 0;
        ok = 0;
        while (!ok && n < 500) begin
            @(negedge clk);
            ok = hdr ? s_hdr_ready : s_tready;
            if (ok && hdr) hs_q.push_back(cyc);
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drive_hdrs(input bit gap);
        hdr_t h;
        bit ok;
        @(posedge clk);
        #1;
        while (hq.size() > 0) begin
            h = hq.pop_front();
            if (gap) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            s_hdr_valid = 1;
            s_hdr_data = h.d;
            s_hdr_np = h.np;
            wait_acc(1, ok);
            chk("hdr_accept", 96'(ok), 1);
            s_hdr_valid = 0;
        end
    endtask

    task automatic drive_pay(input bit gap);
        beat_t b;
        bit ok;
        @(posedge clk);
        #1;
        while (pq.size() > 0) begin
            b = pq.pop_front();
            if (gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            s_tvalid = 1;
            s_tdata = b.d;
            s_tkeep = b.k;
            s_tlast = b.l;
            wait_acc(0, ok);
            chk("pay_accept", 96'(ok), 1);
            s_tvalid = 0;
        end
    endtask

    task automatic run(input bit gap, input int mode);
        int n;
        tr_mode = mode;
        fork
            drive_hdrs(gap);
            drive_pay(gap);
        join
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 96'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        m_tready = (tr_mode == 0) ? 1'b1 : (tr_mode == 1) ? ~m_tready : 1'($urandom_range(0, 1));
    end

    // Monitor: order/content, stall stability, header latency, post-tlast behaviour.
    initial begin
        beat_t       e;
        logic [73:0] hold_v;
        bit          stall_p, last_p, shown;
        stall_p = 0; last_p = 0; shown = 0; hold_v = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_p = 0; last_p = 0; shown = 0;
            end else begin
                if (stall_p) chk("hold", 96'({m_tvalid, m_tdata, m_tkeep, m_tlast}), 96'(hold_v));
                if (last_p) begin
                    chk("idle_after_last", 96'(out_state), 0);
                    chk("pkt_count", 96'(out_pkt_count), 96'(exp_pkts));
                    if (s_hdr_valid) chk("b2b_hdr_ready", 96'(s_hdr_ready), 1);
                end
                if (out_state == 2'd1) chk("hdr_phase_readies", 96'({s_tready, s_hdr_ready}), 0);
                if (m_tvalid && !shown && exp_q.size() > 0 && exp_q[0].first && hs_q.size() > 0) begin
                    chk("hdr_latency", 96'(cyc - hs_q.pop_front()), 1);
                    shown = 1;
                end
                last_p = 0;
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) chk("exp_q_size", 96'(exp_q.size()), 1);
                    else begin
                        e = exp_q.pop_front();
                        chk("beat", 96'({m_tdata, m_tkeep, m_tlast}), 96'({e.d, e.k, e.l}));
                        if (e.l) begin
                            exp_pkts++;
                            last_p = 1;
                        end
                        shown = 0;
                    end
                end
                stall_p = m_tvalid && !m_tready;
                hold_v = {m_tvalid, m_tdata, m_tkeep, m_tlast};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hdr_t  h;
        beat_t b;
        bit    ok;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 96'(m_tvalid), 0);
        chk("rst_m_tlast", 96'(m_tlast), 0);
        chk("rst_s_tready", 96'(s_tready), 0);
        chk("rst_hdr_ready", 96'(s_hdr_ready), 0);
        chk("rst_state", 96'(out_state), 0);
        chk("rst_count", 96'(out_count), 0);
        chk("rst_pkt_count", 96'(out_pkt_count), 0);
        rst = 0;
        @(negedge clk);
        chk("idle_hdr_ready", 96'(s_hdr_ready), 1);
        @(posedge clk);
        #1;

        add_pkt({64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 0, 3, 64'h5000, 0);
        run(0, 0);
        chk("basic_pkts", 96'(out_pkt_count), 1);

        add_pkt({$urandom, $urandom, $urandom, $urandom}, 1, 0, 0, 0);
        run(0, 0);
        chk("hdr_only_state", 96'(out_state), 0);
        chk("hdr_only_pkts", 96'(out_pkt_count), 2);

        for (int i = 0; i < 4; i++) add_pkt({$urandom, $urandom, $urandom, $urandom}, i == 2, i + 1, 64'h6000 + 64'(i * 16), 0);
        run(0, 1);

        add_pkt({$urandom, $urandom, $urandom, $urandom}, 0, 1, 0, 1);
        add_pkt({$urandom, $urandom, $urandom, $urandom}, 0, 2, 0, 1);
        run(0, 0);
        chk("b2b_pkts", 96'(out_pkt_count), 96'(exp_pkts));

        for (int i = 0; i < 30; i++) begin
            ok = ($urandom_range(0, 3) == 0);
            add_pkt({$urandom, $urandom, $urandom, $urandom}, ok, $urandom_range(1, 4), 0, 1);
        end
        run(1, 2);

        tr_mode = 0;
        add_pkt({$urandom, $urandom, $urandom, $urandom}, 0, 4, 64'h7000, 0);
        h = hq.pop_front();
        s_hdr_valid = 1;
        s_hdr_data = h.d;
        s_hdr_np = 0;
        wait_acc(1, ok);
        s_hdr_valid = 0;
        b = pq.pop_front();
        s_tvalid = 1; s_tdata = b.d; s_tkeep = b.k; s_tlast = b.l;
        wait_acc(0, ok);
        chk("rst_p0_accept", 96'(ok), 1);
        b = pq.pop_front();
        s_tdata = b.d; s_tkeep = b.k; s_tlast = b.l;
        chk("pre_rst_state", 96'(out_state), 2);
        rst = 1;
        #1;
        chk("midrst_m_tvalid", 96'(m_tvalid), 0);
        chk("midrst_state", 96'(out_state), 0);
        chk("midrst_count", 96'(out_count), 0);
        chk("midrst_pkt_count", 96'(out_pkt_count), 0);
        chk("midrst_readies", 96'({s_tready, s_hdr_ready}), 0);
        exp_q.delete(); pq.delete(); hs_q.delete();
        exp_pkts = 0;
        s_tvalid = 0; s_tlast = 0;
        @(posedge clk);
        #1;
        rst = 0;
        add_pkt({$urandom, $urandom, $urandom, $urandom}, 0, 2, 64'h8000, 0);
        run(0, 2);
        chk("post_rst_pkts", 96'(out_pkt_count), 1);

        @(negedge clk);
        force dut.pkt_count_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.pkt_count_q;
        exp_pkts = 16'hFFFF;
        @(negedge clk);
        chk("preload", 96'(out_pkt_count), 96'h FFFF);
        @(posedge clk);
        #1;
        add_pkt({$urandom, $urandom, $urandom, $urandom}, 1, 0, 0, 0);
        run(0, 0);
        chk("wrap", 96'(out_pkt_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
